// File: rtl/exe_stage.sv
// ARM execute stage: Val2 generation, ALU, NZCV status register and branch target.
// Define EXE_MUL_EN to add the multi-cycle shift-add multiplier on EX_CMD 1010.
module exe_stage #(
  parameter int unsigned WORD_WIDTH            = 32,
  parameter int unsigned SIGNED_IMM_WIDTH      = 24,
  parameter int unsigned SHIFTER_OPERAND_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       EX_CMD,
  input  logic                             Imm,
  input  logic                             MEM_R_EN,
  input  logic                             MEM_W_EN,
  input  logic                             S,
  input  logic                             B,
  input  logic [WORD_WIDTH-1:0]            PC,
  input  logic [WORD_WIDTH-1:0]            Val_Rn,
  input  logic [WORD_WIDTH-1:0]            Val_Rm,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
  input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate,
  output logic [WORD_WIDTH-1:0]            alu_result,
  output logic                             branch_taken,
  output logic [WORD_WIDTH-1:0]            branch_addr,
  output logic [3:0]                       status_register,
  output logic                             stall
);

  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;

  logic [3:0]            status_q;
  logic [WORD_WIDTH-1:0] val2;
  logic [WORD_WIDTH-1:0] res;
  logic [WORD_WIDTH:0]   sum;
  logic                  c_new;
  logic                  v_new;
  logic                  flags_we;
  logic                  mul_done;
  logic [WORD_WIDTH-1:0] mul_product;

  function automatic logic [WORD_WIDTH-1:0] ror(input logic [WORD_WIDTH-1:0] x,
                                                input logic [4:0]            amt);
    return (x >> amt) | (x << (WORD_WIDTH - amt));
  endfunction

  assign branch_taken    = B;
  assign branch_addr     = PC + {{(WORD_WIDTH - SIGNED_IMM_WIDTH - 2){signed_immediate[SIGNED_IMM_WIDTH-1]}},
                                 signed_immediate, 2'b00};
  assign status_register = status_q;

  always_comb begin
    val2 = Val_Rm;
    if (MEM_R_EN || MEM_W_EN) begin
      val2 = {{(WORD_WIDTH - SHIFTER_OPERAND_WIDTH){1'b0}}, shifter_operand};
    end else if (Imm) begin
      val2 = ror({{(WORD_WIDTH - 8){1'b0}}, shifter_operand[7:0]}, {shifter_operand[11:8], 1'b0});
    end else begin
      unique case (shifter_operand[6:5])
        2'b00:   val2 = Val_Rm << shifter_operand[11:7];
        2'b01:   val2 = Val_Rm >> shifter_operand[11:7];
        2'b10:   val2 = WORD_WIDTH'($signed(Val_Rm) >>> shifter_operand[11:7]);
        default: val2 = ror(Val_Rm, shifter_operand[11:7]);
      endcase
    end
  end

  always_comb begin
    sum      = '0;
    res      = '0;
    c_new    = status_q[1];
    v_new    = status_q[0];
    flags_we = 1'b1;
    unique case (EX_CMD)
      CmdMov: res = val2;
      CmdMvn: res = ~val2;
      CmdAnd: res = Val_Rn & val2;
      CmdOrr: res = Val_Rn | val2;
      CmdEor: res = Val_Rn ^ val2;
      CmdAdd, CmdAdc: begin
        sum   = {1'b0, Val_Rn} + {1'b0, val2} +
                {{WORD_WIDTH{1'b0}}, (EX_CMD == CmdAdc) & status_q[1]};
        res   = sum[WORD_WIDTH-1:0];
        c_new = sum[WORD_WIDTH];
        v_new = (Val_Rn[WORD_WIDTH-1] == val2[WORD_WIDTH-1]) &&
                (res[WORD_WIDTH-1] != Val_Rn[WORD_WIDTH-1]);
      end
      CmdSub, CmdSbc: begin
        // Rn + ~Val2 + carry-in; carry out is the ARM not-borrow.
        sum   = {1'b0, Val_Rn} + {1'b0, ~val2} +
                {{WORD_WIDTH{1'b0}}, (EX_CMD == CmdSub) | status_q[1]};
        res   = sum[WORD_WIDTH-1:0];
        c_new = sum[WORD_WIDTH];
        v_new = (Val_Rn[WORD_WIDTH-1] != val2[WORD_WIDTH-1]) &&
                (res[WORD_WIDTH-1] != Val_Rn[WORD_WIDTH-1]);
      end
      default: flags_we = 1'b0;
    endcase
    if (mul_done) begin
      res      = mul_product;
      c_new    = status_q[1];
      v_new    = status_q[0];
      flags_we = 1'b1;
    end
  end

  assign alu_result = res;

`ifdef EXE_MUL_EN
  localparam logic [3:0]  CmdMul = 4'b1010;
  localparam int unsigned CntW   = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

  mul_state_e            state_q;
  logic [WORD_WIDTH-1:0] mcand_q;
  logic [WORD_WIDTH-1:0] mplier_q;
  logic [WORD_WIDTH-1:0] acc_q;
  logic [CntW-1:0]       count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (EX_CMD == CmdMul) begin
            mcand_q  <= Val_Rn;
            mplier_q <= val2;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (count_q == CntW'(WORD_WIDTH - 1)) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall       = !rst && (((state_q == StIdle) && (EX_CMD == CmdMul)) || (state_q == StBusy));
  assign mul_done    = (state_q == StDone);
  assign mul_product = acc_q;
`else
  assign stall       = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 4'b0000;
    end else if (S && !stall && flags_we) begin
      status_q <= {res[WORD_WIDTH-1], ~|res, c_new, v_new};
    end
  end

endmodule
